// File: rtl/act_pkg.sv
// Shared types and fixed-point constants for the streaming activation unit.
package act_pkg;

    typedef enum logic [1:0] {
        ACT_HSIG  = 2'd0,
        ACT_HTANH = 2'd1,
        ACT_RELU  = 2'd2,
        ACT_LRELU = 2'd3
    } act_mode_e;

    // Negative inputs of leaky-ReLU are scaled by 1/8.
    localparam int LRELU_SHIFT = 3;

    function automatic int act_one(input int frac_bits);
        return 1 << frac_bits;
    endfunction

    function automatic int act_half(input int frac_bits);
        return act_one(frac_bits) >> 1;
    endfunction

    function automatic int act_two(input int frac_bits);
        return act_one(frac_bits) << 1;
    endfunction

endpackage

// File: rtl/act_lane.sv
// Combinational single-element activation: x, mode -> y, sat.
// Comparisons run two bits wider than the data so the +/-TWO bounds never wrap.
module act_lane
    import act_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8
) (
    input  logic signed [DATA_WIDTH-1:0] x,
    input  act_mode_e                    mode,
    output logic signed [DATA_WIDTH-1:0] y,
    output logic                         sat
);

    localparam int IW = DATA_WIDTH + 2;
    localparam logic signed [IW-1:0] ONE_E     = IW'(act_one(FRAC_BITS));
    localparam logic signed [IW-1:0] HALF_E    = IW'(act_half(FRAC_BITS));
    localparam logic signed [IW-1:0] TWO_E     = IW'(act_two(FRAC_BITS));
    localparam logic signed [IW-1:0] NEG_ONE_E = -ONE_E;
    localparam logic signed [IW-1:0] NEG_TWO_E = -TWO_E;

    logic signed [IW-1:0] xe;

    assign xe = {{2{x[DATA_WIDTH-1]}}, x};

    // Piecewise-linear function select; results always fit DATA_WIDTH.
    always_comb begin
        y   = x;
        sat = 1'b0;
        case (mode)
            ACT_HSIG: begin
                if (xe <= NEG_TWO_E) begin
                    y   = '0;
                    sat = 1'b1;
                end else if (xe >= TWO_E) begin
                    y   = DATA_WIDTH'(ONE_E);
                    sat = 1'b1;
                end else begin
                    y = DATA_WIDTH'(HALF_E + (xe >>> 2));
                end
            end
            ACT_HTANH: begin
                if (xe < NEG_ONE_E) begin
                    y   = DATA_WIDTH'(NEG_ONE_E);
                    sat = 1'b1;
                end else if (xe > ONE_E) begin
                    y   = DATA_WIDTH'(ONE_E);
                    sat = 1'b1;
                end
            end
            ACT_RELU: begin
                if (xe[IW-1]) y = '0;
            end
            ACT_LRELU: begin
                if (xe[IW-1]) y = DATA_WIDTH'(xe >>> LRELU_SHIFT);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/act_stream_unit.sv
// Streaming multi-lane activation unit: 2-stage back-pressured pipeline.
// Stage 1 holds raw beats with their mode/last tags, stage 2 holds results.
module act_stream_unit
    import act_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int VEC_LEN    = 128
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    mode,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*DATA_WIDTH-1:0]   out_data,
    output logic [LANES-1:0]              out_sat,
    output logic                          out_last,
    output logic                          done
);

    localparam int BEATS = VEC_LEN / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0]                   beat_cnt_q, beat_cnt_d;
    act_mode_e                          vec_mode_q, vec_mode_d;
    logic [2:1]                         vld_pipe_q, vld_pipe_d;
    logic [LANES-1:0][DATA_WIDTH-1:0]   s1_data_q, s1_data_d;
    act_mode_e                          s1_mode_q, s1_mode_d;
    logic                               s1_last_q, s1_last_d;
    logic [LANES-1:0][DATA_WIDTH-1:0]   s2_data_q, s2_data_d;
    logic [LANES-1:0]                   s2_sat_q, s2_sat_d;
    logic                               s2_last_q, s2_last_d;
    logic                               done_q, done_d;

    logic [LANES-1:0][DATA_WIDTH-1:0]   lane_y;
    logic [LANES-1:0]                   lane_sat;
    logic                               s1_adv, s2_adv, in_acc, is_last;
    act_mode_e                          beat_mode;

    // Handshake: each stage moves when its downstream slot is free or draining.
    always_comb begin
        s2_adv    = !vld_pipe_q[2] || out_ready;
        s1_adv    = !vld_pipe_q[1] || s2_adv;
        in_ready  = s1_adv && !reset;
        in_acc    = in_valid && in_ready;
        is_last   = (beat_cnt_q == LAST_BEAT);
        beat_mode = (beat_cnt_q == '0) ? act_mode_e'(mode) : vec_mode_q;
    end

    // Next-state for the beat counter, vector mode and both pipeline stages.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        vec_mode_d = vec_mode_q;
        vld_pipe_d = vld_pipe_q;
        s1_data_d  = s1_data_q;
        s1_mode_d  = s1_mode_q;
        s1_last_d  = s1_last_q;
        s2_data_d  = s2_data_q;
        s2_sat_d   = s2_sat_q;
        s2_last_d  = s2_last_q;
        done_d     = vld_pipe_q[2] && out_ready && s2_last_q;

        if (in_acc) begin
            beat_cnt_d = is_last ? '0 : beat_cnt_q + 1'b1;
            vec_mode_d = beat_mode;
        end

        if (s1_adv) begin
            vld_pipe_d[1] = in_acc;
            if (in_acc) begin
                s1_data_d = in_data;
                s1_mode_d = beat_mode;
                s1_last_d = is_last;
            end
        end

        if (s2_adv) begin
            vld_pipe_d[2] = vld_pipe_q[1];
            s2_data_d     = lane_y;
            s2_sat_d      = lane_sat;
            s2_last_d     = vld_pipe_q[1] && s1_last_q;
        end
    end

    // State registers; reset drops every in-flight beat and restarts the vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt_q <= '0;
            vec_mode_q <= ACT_HSIG;
            vld_pipe_q <= '0;
            s1_data_q  <= '0;
            s1_mode_q  <= ACT_HSIG;
            s1_last_q  <= 1'b0;
            s2_data_q  <= '0;
            s2_sat_q   <= '0;
            s2_last_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            vec_mode_q <= vec_mode_d;
            vld_pipe_q <= vld_pipe_d;
            s1_data_q  <= s1_data_d;
            s1_mode_q  <= s1_mode_d;
            s1_last_q  <= s1_last_d;
            s2_data_q  <= s2_data_d;
            s2_sat_q   <= s2_sat_d;
            s2_last_q  <= s2_last_d;
            done_q     <= done_d;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        act_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .FRAC_BITS  (FRAC_BITS)
        ) u_lane (
            .x    (s1_data_q[g]),
            .mode (s1_mode_q),
            .y    (lane_y[g]),
            .sat  (lane_sat[g])
        );
    end

    assign out_valid = vld_pipe_q[2];
    assign out_data  = s2_data_q;
    assign out_sat   = s2_sat_q;
    assign out_last  = s2_last_q;
    assign done      = done_q;

endmodule

// File: tb/tb_act_stream_unit.sv
// Directed bench for act_stream_unit: single beats per mode, full vectors,
// random back-pressure, back-to-back vectors and mid-vector reset.
module tb_act_stream_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mode;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [3:0]  out_sat;
    logic        out_last;
    logic        done;

    int checks = 0;
    int errors = 0;

    act_stream_unit #(
        .LANES(4), .DATA_WIDTH(16), .FRAC_BITS(8), .VEC_LEN(128)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .out_last(out_last), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = 2'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One beat through an idle pipe, checking the 2-cycle latency.
    task automatic single(input string tag, input logic [1:0] m, input logic [63:0] d,
                          input logic [63:0] exp_d, input logic [3:0] exp_s);
        do_reset();
        in_valid = 1'b1; mode = m; in_data = d;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_lat1"}, out_valid, 1'b0);
        @(negedge clk);
        chk({tag, "_vld"}, out_valid, 1'b1);
        chk({tag, "_data"}, out_data, exp_d);
        chk({tag, "_sat"}, out_sat, exp_s);
        chk({tag, "_last"}, out_last, 1'b0);
        @(negedge clk);
        chk({tag, "_drain"}, out_valid, 1'b0);
    endtask

    // Beats of small negative values: hard-tanh passes them through unchanged,
    // while ReLU/leaky/hsig would not.
    function automatic logic [63:0] tanh_beat(input int b);
        logic [63:0] v;
        for (int i = 0; i < 4; i++) v[i*16 +: 16] = 16'hFF80 - 16'(b) - 16'(i);
        return v;
    endfunction

    // x = 4*(b+16i) so hsig gives 0x80 + b + 16i.
    function automatic logic [63:0] hsig_in(input int b);
        logic [63:0] v;
        for (int i = 0; i < 4; i++) v[i*16 +: 16] = 16'(4 * (b + 16 * i));
        return v;
    endfunction

    function automatic logic [63:0] hsig_exp(input int b);
        logic [63:0] v;
        for (int i = 0; i < 4; i++) v[i*16 +: 16] = 16'(128 + b + 16 * i);
        return v;
    endfunction

    // Full hard-tanh vector at full rate; mode toggles after beat 0.
    task automatic run_tanh_vec(input string tag);
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            chk({tag, "_vld"}, out_valid, (c >= 2 && c <= 33));
            if (c >= 2 && c <= 33) begin
                chk({tag, "_data"}, out_data, tanh_beat(c - 2));
                chk({tag, "_last"}, out_last, (c - 2 == 31));
            end
            chk({tag, "_done"}, done, (c == 34));
            if (c < 32) begin
                in_valid = 1'b1;
                mode     = (c == 0) ? 2'd1 : ((c % 2 == 1) ? 2'd2 : 2'd3);
                in_data  = tanh_beat(c);
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    initial begin
        int sent, rcv, cyc, dcount;
        logic        held_v;
        logic [63:0] held_d;
        logic [3:0]  held_s;
        logic        held_l;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = 2'd0; in_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 64'h0);
        chk("rst_out_sat", out_sat, 4'h0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_done", done, 1'b0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);

        single("hsig", 2'd0, 64'hFC00_0200_FF00_0100, 64'h0000_0100_0040_00C0, 4'b1100);
        single("htanh", 2'd1, 64'h0000_FD00_0300_0080, 64'h0000_FF00_0100_0080, 4'b0110);
        single("lrelu", 2'd3, 64'hFFF9_8000_0100_FF00, 64'hFFFF_F000_0100_FFE0, 4'b0000);
        single("relu", 2'd2, 64'h0000_8000_0100_FF00, 64'h0000_0000_0100_0000, 4'b0000);
        single("hsig_bnd", 2'd0, 64'h0200_01FF_FE01_FE00, 64'h0100_00FF_0000_0000, 4'b1001);
        single("htanh_bnd", 2'd1, 64'h0101_0100_FEFF_FF00, 64'h0100_0100_FF00_FF00, 4'b1010);

        do_reset();
        run_tanh_vec("fullvec");

        // Random back-pressure with a bounded cycle budget.
        do_reset();
        sent = 0; rcv = 0; cyc = 0; held_v = 1'b0;
        held_d = '0; held_s = '0; held_l = 1'b0;
        while (rcv < 32 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (held_v) begin
                chk("stall_vld", out_valid, 1'b1);
                chk("stall_data", out_data, held_d);
                chk("stall_sat", out_sat, held_s);
                chk("stall_last", out_last, held_l);
            end
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (sent < 32);
            mode      = 2'd0;
            in_data   = hsig_in(sent);
            #1;
            chk("stall_in_ready", in_ready, !((sent - rcv) == 2 && !out_ready));
            if (out_valid && out_ready) begin
                chk("stall_out", out_data, hsig_exp(rcv));
                chk("stall_out_last", out_last, (rcv == 31));
                rcv++;
            end
            held_v = out_valid && !out_ready;
            held_d = out_data; held_s = out_sat; held_l = out_last;
            if (in_valid && in_ready) sent++;
        end
        chk("stall_rcv_count", 64'(rcv), 64'd32);
        chk("stall_sent_count", 64'(sent), 64'd32);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("stall_done", done, 1'b1);
        @(negedge clk);
        chk("stall_done_pulse", done, 1'b0);

        // Back-to-back vectors: hsig then ReLU, no gap.
        do_reset();
        dcount = 0;
        for (int c = 0; c < 68; c++) begin
            @(negedge clk);
            chk("b2b_vld", out_valid, (c >= 2 && c <= 65));
            if (c >= 2 && c <= 65) begin
                chk("b2b_data", out_data,
                    (c - 2 < 32) ? 64'h00C0_0040_00C0_0040 : 64'h0100_0000_0100_0000);
                chk("b2b_last", out_last, ((c - 2) % 32 == 31));
            end
            chk("b2b_done", done, (c == 34 || c == 66));
            if (done) dcount++;
            in_valid = (c < 64);
            mode     = (c < 32) ? 2'd0 : 2'd2;
            in_data  = 64'h0100_FF00_0100_FF00;
        end
        chk("b2b_done_count", 64'(dcount), 64'd2);

        // Reset with both stages full at beat 10.
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            in_valid = 1'b1; mode = 2'd1; in_data = tanh_beat(c);
        end
        @(negedge clk);
        chk("mid_pipe_full", out_valid, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_vld", out_valid, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b0);
        reset = 1'b0; in_valid = 1'b0;
        run_tanh_vec("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/act_stream_unit.md
# act_stream_unit

Multi-lane, multi-mode streaming activation unit for the neural datapath: applies hard-sigmoid, hard-tanh, ReLU or leaky-ReLU to signed fixed-point vectors delivered LANES elements per beat over valid/ready handshakes. It sits between the matrix-multiply accumulator output and the layer buffer. It replaces the single-function, index-scanning sigmoid block with a back-pressured 2-stage pipeline and per-vector mode selection.

## Interface
- LANES, 4, elements processed per beat
- DATA_WIDTH, 16, bits per element, signed two's complement
- FRAC_BITS, 8, fractional bits (Q format)
- VEC_LEN, 128, elements per vector; must be a multiple of LANES
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- mode  in  2  0 hard-sigmoid, 1 hard-tanh, 2 ReLU, 3 leaky-ReLU; sampled on first beat of each vector
- in_valid  in  1  input beat valid
- in_ready  out  1  unit accepts beat
- in_data  in  LANES*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts beat
- out_data  out  LANES*DATA_WIDTH  results, same lane packing
- out_sat  out  LANES  per-lane flag: result was clamped
- out_last  out  1  final beat of a vector
- done  out  1  one-cycle pulse when the out_last beat transfers

## Operation
- Beat transfers on the input when in_valid && in_ready; on the output when out_valid && out_ready.
- Beat counter counts accepted input beats 0..VEC_LEN/LANES-1, then wraps to 0. When the counter is 0, the accepted beat latches mode into vec_mode and uses it. Later beats use vec_mode; mode changes mid-vector are ignored.
- Each beat carries its mode and a last tag (counter == VEC_LEN/LANES-1) through the pipeline. Consecutive vectors with different modes may be in flight together.
- Constants: ONE = 1<<FRAC_BITS, HALF = ONE>>1, TWO = ONE<<1.
- Hard-sigmoid: x <= -TWO gives 0 (sat). x >= TWO gives ONE (sat). Otherwise HALF + (x>>>2).
- Hard-tanh: x < -ONE gives -ONE (sat). x > ONE gives ONE (sat). Otherwise x.
- ReLU: x < 0 gives 0 (sat=0). Otherwise x.
- Leaky-ReLU: x < 0 gives x>>>3 (arithmetic, rounds toward -inf). Otherwise x.
- Intermediates are computed at DATA_WIDTH+2 bits. Results are always representable, so there is no output overflow.
- Lanes are fully independent; all lanes share one beat's mode.

## Timing
- Stage 1 registers the inputs plus the mode and last tags. Stage 2 registers results, sat and last.
- Latency is 2 cycles from input transfer to out_valid with no back-pressure. Throughput is 1 beat/cycle.
- Stage 2 advances when !s2_valid || out_ready. Stage 1 advances when !s1_valid || stage 2 advances. in_ready = stage-1 advance condition, combinational from out_ready.
- out_data, out_sat and out_last are held stable while out_valid && !out_ready.
- done = 1 in the cycle after the out_last beat transfers, for exactly 1 cycle.
- Reset values: in_ready 0 during reset, then 1. out_valid, out_last, done and out_sat are 0. out_data is 0. Beat counter is 0, vec_mode is 0, and both stage valids are 0.
- Reset mid-vector discards all in-flight beats. The next accepted beat is treated as beat 0 of a new vector.
- Simultaneous input accept and output transfer in one cycle is legal and sustains full throughput.
- in_valid dropping mid-vector pauses the counter; there is no timeout.

## Structure
- Package act_pkg holds:
  - the mode enum (ACT_HSIG, ACT_HTANH, ACT_RELU, ACT_LRELU)
  - functions computing ONE, HALF and TWO from FRAC_BITS
  - the leaky shift constant LRELU_SHIFT = 3
- Sub-module act_lane is the combinational single-element function (x, mode → y, sat), instantiated LANES times in a generate loop ahead of stage 2.
- The top level owns the handshake, the beat counter and the tag pipeline.

## Test plan
- Hard-sigmoid, FRAC 8, lanes 0x0100, 0xFF00, 0x0200, 0xFC00 → 0x00C0, 0x0040, 0x0100 (sat), 0x0000 (sat). out_valid 2 cycles after accept.
- Hard-tanh lanes 0x0080, 0x0300, 0xFD00, 0x0000 → 0x0080, 0x0100 (sat), 0xFF00 (sat), 0x0000. Leaky-ReLU 0xFF00 → 0xFFE0; ReLU 0xFF00 → 0x0000.
- Full vector of 32 beats, out_ready always 1: out_last and done occur only on beat 32. Assert mode toggling on beats 1–31 has no effect.
- Random out_ready stalls (50%): no beat lost or duplicated, data stable while stalled, in_ready low when both stages are full and out_ready is 0.
- Back-to-back vectors in mode 0 then mode 2 with no gap: each vector's beats use their own mode, and done pulses twice.
- Assert reset at beat 10 of a vector with the pipeline full: out_valid is 0 the next cycle. The following vector produces out_last on its own 32nd beat.
